vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//   Shares one single-port video SRAM between the SVGA scanout fetcher (display) and a host
//   read/write port. Display has priority so the 40 MHz pixel pipeline never underruns. Host
//   traffic fills idle slots plus one guaranteed slot after every DISP_BURST display grants,
//   unless the display flags urgency. Sits between the line-buffer filler, the host bus bridge
//   and the SRAM pins; all ports are in the pixel-clock domain.
// PARAMETERS
//   AW          15  address width (words)
//   DW          16  data width
//   MEM_LAT     1   SRAM read latency: cycles from mem_en (read) to mem_rdata valid, 1..4
//   DISP_BURST  8   consecutive display grants allowed while host waits; 1..255
// PORTS
//   clk          in   1   pixel clock; all logic on posedge
//   rst_n        in   1   asynchronous active-low reset
//   disp_req     in   1   display read request; hold with disp_addr stable until disp_gnt
//   disp_urgent  in   1   line buffer near empty; suppresses forced host slots
//   disp_addr    in   AW  display read address
//   disp_gnt     out  1   combinational accept for this cycle
//   disp_rvalid  out  1   one-cycle pulse, disp_rdata valid
//   disp_rdata   out  DW  display read data
//   host_req     in   1   host request; hold with host_we/addr/wdata stable until host_gnt
//   host_we      in   1   1 = write, 0 = read
//   host_addr    in   AW  host address
//   host_wdata   in   DW  host write data
//   host_gnt     out  1   combinational accept for this cycle
//   host_rvalid  out  1   one-cycle pulse, host_rdata valid (reads only)
//   host_rdata   out  DW  host read data
//   mem_en       out  1   SRAM access strobe
//   mem_we       out  1   SRAM write enable (valid with mem_en)
//   mem_addr     out  AW  SRAM address
//   mem_wdata    out  DW  SRAM write data
//   mem_rdata    in   DW  SRAM read data, MEM_LAT cycles after read strobe
// BEHAVIOUR
//   - Reset (async assert, sync deassert in the reset-sync block upstream): mem_en, mem_we,
//     disp_rvalid, host_rvalid = 0; mem_addr, mem_wdata, disp_rdata, host_rdata = 0;
//     run counter = 0; read-tag pipeline cleared.
//   - At most one grant per cycle; disp_gnt & host_gnt never both 1. A transfer is accepted
//     in cycle t when req & gnt are both high.
//   - Grant decision in cycle t (run = 8-bit count of consecutive display grants with host waiting):
//       display if disp_req & (disp_urgent | ~host_req | run < DISP_BURST)
//       else host if host_req
//       else none.
//   - run update: display grant with host_req high -> run+1, saturating at 255; display grant
//     with host_req low -> 0; host grant -> 0; no grant -> 0.
//   - With disp_urgent held high, host can starve indefinitely. This is intended.
//   - Memory port is registered: an access accepted in cycle t drives mem_en/mem_we/mem_addr/mem_wdata
//     in cycle t+1 only. mem_en = 0 in cycles with no accepted transfer. mem_wdata holds its
//     last value on reads/idle.
//   - Reads: a tag {valid, owner} shifts through a (1+MEM_LAT)-deep pipeline. Data is registered
//     into the owner's rdata; the owner's rvalid pulses in cycle t+2+MEM_LAT (MEM_LAT=1 -> t+3).
//     Back-to-back reads produce back-to-back rvalid pulses in acceptance order.
//   - Writes: no rvalid; complete in cycle t+1.
//   - Non-owner rdata holds its previous value; rvalid is never asserted for writes or idle slots.
//   - Reset mid-operation: in-flight read tags are discarded; no rvalid pulses after reset
//     release for pre-reset requests.
//   - Requester dropping req without gnt is legal; no side effects.
// TESTING
//   1. Host only: host write addr 0x0010 data 0xBEEF, then read 0x0010 -> mem_we=1 cycle t+1;
//      host_rvalid with host_rdata=0xBEEF at read-accept+3 (MEM_LAT=1).
//   2. Display 20-cycle continuous req, host_req held, disp_urgent=0, DISP_BURST=8 ->
//      grants D x8, H x1, D x8, H x1, D x2; run resets after each H.
//   3. Same as 2 with disp_urgent=1 -> 20 consecutive display grants, host_gnt never high.
//   4. Alternating D read / H read every cycle, MEM_LAT=3 -> each rvalid at accept+5, routed to
//      the correct owner, order preserved, no lost or duplicated pulses.
//   5. rst_n low for 2 cycles with 3 reads in flight -> all outputs 0 immediately;
//      no rvalid in 10 cycles after release.
//   6. Simultaneous req, run < DISP_BURST, host write -> display wins; host held, granted next
//      idle cycle; exactly one mem_en per accept.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video SRAM between the scanout fetcher and a host port.
// Display has priority. The host gets idle slots plus one forced slot after DISP_BURST
// back-to-back display grants, unless the display reports urgency. The memory port is
// registered, and a read tag follows each access down to the returned SRAM data.
module vram_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int DISP_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic          disp_urgent,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } tag_t;

  localparam logic [7:0] RUN_LIMIT = 8'(DISP_BURST);

  logic [7:0]         run_q, run_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  tag_t [MEM_LAT:0]   tag_q, tag_d;
  logic               disp_rvalid_q, disp_rvalid_d;
  logic               host_rvalid_q, host_rvalid_d;
  logic [DW-1:0]      disp_rdata_q, disp_rdata_d;
  logic [DW-1:0]      host_rdata_q, host_rdata_d;
  tag_t               tag_out;

  // Grant selection: display first unless the host has waited out a full burst.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    if (disp_req && (disp_urgent || !host_req || (run_q < RUN_LIMIT))) begin
      disp_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end
  end

  // Run counter: consecutive display grants while the host is waiting, saturating.
  always_comb begin
    run_d = 8'd0;
    if (disp_gnt && host_req) begin
      run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end
  end

  // Memory port request for next cycle; address and write data hold when idle.
  always_comb begin
    mem_en_d    = disp_gnt | host_gnt;
    mem_we_d    = host_gnt & host_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_gnt) begin
      mem_addr_d = disp_addr;
    end else if (host_gnt) begin
      mem_addr_d = host_addr;
      if (host_we) begin
        mem_wdata_d = host_wdata;
      end
    end
  end

  // Read tag pipeline: stage 0 rides with mem_en, stage MEM_LAT lines up with mem_rdata.
  always_comb begin
    tag_d = tag_q;
    for (int i = MEM_LAT; i > 0; i--) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_d[0].vld   = disp_gnt | (host_gnt & ~host_we);
    tag_d[0].owner = host_gnt ? OWN_HOST : OWN_DISP;
  end

  // Read return: steer SRAM data to the tagged owner; the other rdata holds.
  always_comb begin
    tag_out       = tag_q[MEM_LAT];
    disp_rvalid_d = tag_out.vld && (tag_out.owner == OWN_DISP);
    host_rvalid_d = tag_out.vld && (tag_out.owner == OWN_HOST);
    disp_rdata_d  = disp_rvalid_d ? mem_rdata : disp_rdata_q;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag pipeline is reset, not just the data path: a stale valid bit would fire
      // an rvalid after reset for a request that no longer exists.
      run_q         <= 8'd0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tag_q         <= '0;
      disp_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
      run_q         <= run_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tag_q         <= tag_d;
      disp_rvalid_q <= disp_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule
